// File: rtl/rd_pkg.sv
// rtl/rd_pkg.sv - shared constants, disparity type and popcount sizing for rd_monitor
package rd_pkg;

  // Running disparity encoding on rd_out
  localparam logic RD_NEG = 1'b0;
  localparam logic RD_POS = 1'b1;

  // Wide enough to hold +/-SYM_W for any realistic symbol width
  localparam int DISP_W = 16;
  typedef logic signed [DISP_W-1:0] disp_t;

  // Bits needed to count every one in a symbol without truncation
  function automatic int clog2_ones(input int sym_w);
    return $clog2(sym_w + 1);
  endfunction

endpackage

// File: rtl/rd_lane.sv
// rtl/rd_lane.sv - one lane: popcount, disparity classification, RD register and error flags
module rd_lane
  import rd_pkg::*;
#(
  parameter int   SYM_W   = 10,
  parameter logic INIT_RD = RD_NEG
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_push,
  input  logic [SYM_W-1:0] i_sym,
  output logic             o_rd,
  output logic             o_err_disp,
  output logic             o_err_rd,
  output logic             o_err_now
);

  localparam int POP_W = clog2_ones(SYM_W);

  if ((SYM_W % 2) != 0 || SYM_W < 4) begin : g_bad_sym_w
    $error("rd_lane: SYM_W must be even and at least 4");
  end

  logic [POP_W-1:0] w_ones;
  disp_t            w_disp;
  logic             w_rd_nxt;
  logic             w_err_disp_nxt;
  logic             w_err_rd_nxt;
  logic             r_rd;
  logic             r_err_disp;
  logic             r_err_rd;

  // Count the ones in the incoming symbol
  always_comb begin
    w_ones = '0;
    for (int b = 0; b < SYM_W; b++) begin
      w_ones = w_ones + POP_W'(i_sym[b]);
    end
  end

  // Disparity = 2*ones - SYM_W; the cast zero-extends the unsigned count first
  assign w_disp = (disp_t'(w_ones) <<< 1) - disp_t'(SYM_W);

  // Classify the symbol against current RD; resync wins over a valid push
  always_comb begin
    w_rd_nxt       = r_rd;
    w_err_disp_nxt = 1'b0;
    w_err_rd_nxt   = 1'b0;
    if (i_start) begin
      w_rd_nxt = INIT_RD;
    end else if (i_push) begin
      if (w_disp == disp_t'(2)) begin
        if (r_rd == RD_POS) w_err_rd_nxt = 1'b1;
        else                w_rd_nxt     = RD_POS;
      end else if (w_disp == -disp_t'(2)) begin
        if (r_rd == RD_NEG) w_err_rd_nxt = 1'b1;
        else                w_rd_nxt     = RD_NEG;
      end else if (w_disp != disp_t'(0)) begin
        w_err_disp_nxt = 1'b1;
        w_rd_nxt       = (w_disp > disp_t'(0)) ? RD_POS : RD_NEG;
      end
    end
  end

  // Register RD and single-cycle error pulses
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rd       <= INIT_RD;
      r_err_disp <= 1'b0;
      r_err_rd   <= 1'b0;
    end else begin
      r_rd       <= w_rd_nxt;
      r_err_disp <= w_err_disp_nxt;
      r_err_rd   <= w_err_rd_nxt;
    end
  end

  assign o_rd       = r_rd;
  assign o_err_disp = r_err_disp;
  assign o_err_rd   = r_err_rd;
  // Unregistered error flag so the shared counter lands in the same cycle as the pulses
  assign o_err_now  = w_err_disp_nxt | w_err_rd_nxt;

endmodule

// File: rtl/rd_monitor.sv
// rtl/rd_monitor.sv - multi-lane running-disparity monitor with saturating error counter
module rd_monitor
  import rd_pkg::*;
#(
  parameter int   LANES   = 1,
  parameter int   SYM_W   = 10,
  parameter int   CNT_W   = 16,
  parameter logic INIT_RD = RD_NEG
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LANES-1:0]       startin,
  input  logic [LANES*SYM_W-1:0] dataout,
  input  logic [LANES-1:0]       pushout,
  input  logic                   clr_cnt,
  output logic [LANES-1:0]       rd_out,
  output logic [LANES-1:0]       err_disp,
  output logic [LANES-1:0]       err_rd,
  output logic [CNT_W-1:0]       err_cnt
);

  if (LANES < 1 || LANES > 16) begin : g_bad_lanes
    $error("rd_monitor: LANES must be in 1..16");
  end

  localparam int SUM_W = $clog2(LANES + 1);
  localparam int EXT_W = ((CNT_W > SUM_W) ? CNT_W : SUM_W) + 1;
  localparam logic [EXT_W-1:0] CNT_MAX = EXT_W'({CNT_W{1'b1}});

  logic [LANES-1:0] w_err_now;
  logic [SUM_W-1:0] w_err_sum;
  logic [EXT_W-1:0] w_total;
  logic [CNT_W-1:0] r_cnt;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    rd_lane #(
      .SYM_W   (SYM_W),
      .INIT_RD (INIT_RD)
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .i_start    (startin[g]),
      .i_push     (pushout[g]),
      .i_sym      (dataout[g*SYM_W +: SYM_W]),
      .o_rd       (rd_out[g]),
      .o_err_disp (err_disp[g]),
      .o_err_rd   (err_rd[g]),
      .o_err_now  (w_err_now[g])
    );
  end

  // Number of lanes erroring this cycle
  always_comb begin
    w_err_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      w_err_sum = w_err_sum + SUM_W'(w_err_now[l]);
    end
  end

  // One extra bit of headroom so overflow is visible before saturation
  assign w_total = EXT_W'(r_cnt) + EXT_W'(w_err_sum);

  // Saturating error counter; clear drops any errors of the same cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clr_cnt) begin
      r_cnt <= '0;
    end else if (w_total > CNT_MAX) begin
      r_cnt <= CNT_MAX[CNT_W-1:0];
    end else begin
      r_cnt <= w_total[CNT_W-1:0];
    end
  end

  assign err_cnt = r_cnt;

endmodule

// File: tb/tb_rd_monitor.sv
// tb/tb_rd_monitor.sv - self-checking bench for rd_monitor with directed and randomized scenarios
module tb_rd_monitor;

  localparam int LANES = 2;
  localparam int SYM_W = 10;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic [LANES-1:0]       startin = '0;
  logic [LANES*SYM_W-1:0] dataout = '0;
  logic [LANES-1:0]       pushout = '0;
  logic                   clr_cnt = 1'b0;
  logic [LANES-1:0]       rd_out;
  logic [LANES-1:0]       err_disp;
  logic [LANES-1:0]       err_rd;
  logic [CNT_W-1:0]       err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [1:0] m_rd   = 2'b00;
  logic [1:0] m_disp = 2'b00;
  logic [1:0] m_rdv  = 2'b00;
  int         m_cnt  = 0;

  rd_monitor #(
    .LANES   (LANES),
    .SYM_W   (SYM_W),
    .CNT_W   (CNT_W),
    .INIT_RD (1'b0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .startin  (startin),
    .dataout  (dataout),
    .pushout  (pushout),
    .clr_cnt  (clr_cnt),
    .rd_out   (rd_out),
    .err_disp (err_disp),
    .err_rd   (err_rd),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of stimulus, step the model from the rules, sample 1ns after the edge
  task automatic cycle(input logic rst_n, input logic [1:0] st, input logic [1:0] pu,
                       input logic [19:0] d, input logic cl);
    int ones;
    int disp;
    int nerr;
    reset = rst_n; startin = st; pushout = pu; dataout = d; clr_cnt = cl;
    @(posedge clk);
    nerr = 0;
    for (int l = 0; l < LANES; l++) begin
      m_disp[l] = 1'b0;
      m_rdv[l]  = 1'b0;
      if (!rst_n || st[l]) begin
        m_rd[l] = 1'b0;
      end else if (pu[l]) begin
        ones = $countones(d[l*SYM_W +: SYM_W]);
        disp = 2 * ones - SYM_W;
        if (disp == 2 || disp == -2) begin
          if (m_rd[l] == (disp > 0)) m_rdv[l] = 1'b1;
          else                       m_rd[l]  = (disp > 0);
        end else if (disp != 0) begin
          m_disp[l] = 1'b1;
          m_rd[l]   = (disp > 0);
        end
      end
      if (m_disp[l] || m_rdv[l]) nerr++;
    end
    if (!rst_n || cl) m_cnt = 0;
    else              m_cnt = (m_cnt + nerr > CMAX) ? CMAX : m_cnt + nerr;
    #1;
  endtask

  function automatic logic [9:0] gen_sym();
    logic [9:0] s;
    logic       tmp;
    int         k;
    int         a;
    int         b;
    if ($urandom_range(0, 3) == 0) return 10'($urandom);
    k = $urandom_range(4, 6);
    s = '0;
    for (int j = 0; j < k; j++) s[j] = 1'b1;
    for (int j = 0; j < 20; j++) begin
      a = $urandom_range(0, 9);
      b = $urandom_range(0, 9);
      tmp = s[a]; s[a] = s[b]; s[b] = tmp;
    end
    return s;
  endfunction

  task automatic test_reset();
    cycle(1'b0, 2'b00, 2'b00, 20'h0, 1'b0);
    cycle(1'b0, 2'b00, 2'b11, 20'hFFFFF, 1'b0);
    n_tests++;
    if (rd_out !== 2'b00 || err_disp !== 2'b00 || err_rd !== 2'b00 || err_cnt !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_state: rd=%b disp=%b rdv=%b cnt=%0d want 00 00 00 0", rd_out, err_disp, err_rd, err_cnt);
    end
  endtask

  task automatic test_neutral();
    cycle(1'b1, 2'b00, 2'b01, {10'b0, 10'b1111100000}, 1'b0);
    n_tests++;
    if (rd_out !== 2'b00 || err_disp !== 2'b00 || err_rd !== 2'b00 || err_cnt !== 4'h0) begin
      n_fail++;
      $display("FAIL neutral: rd=%b disp=%b rdv=%b cnt=%0d want 00 00 00 0", rd_out, err_disp, err_rd, err_cnt);
    end
  endtask

  task automatic test_alternation();
    cycle(1'b1, 2'b00, 2'b01, {10'b0, 10'b1111110000}, 1'b0);
    n_tests++;
    if (rd_out !== 2'b01 || (err_disp | err_rd) !== 2'b00) begin
      n_fail++;
      $display("FAIL alt_pos: rd=%b errs=%b want rd 01 errs 00", rd_out, err_disp | err_rd);
    end
    cycle(1'b1, 2'b00, 2'b01, {10'b0, 10'b1111000000}, 1'b0);
    n_tests++;
    if (rd_out !== 2'b00 || (err_disp | err_rd) !== 2'b00) begin
      n_fail++;
      $display("FAIL alt_neg: rd=%b errs=%b want rd 00 errs 00", rd_out, err_disp | err_rd);
    end
  endtask

  task automatic test_rd_violation();
    cycle(1'b1, 2'b00, 2'b10, {10'b1111110000, 10'b0}, 1'b0);
    n_tests++;
    if (rd_out !== 2'b10 || err_rd !== 2'b00) begin
      n_fail++;
      $display("FAIL rdv_first: rd=%b err_rd=%b want 10 00", rd_out, err_rd);
    end
    cycle(1'b1, 2'b00, 2'b10, {10'b1111110000, 10'b0}, 1'b0);
    n_tests++;
    if (rd_out !== 2'b10 || err_rd !== 2'b10 || err_disp !== 2'b00 || err_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL rdv_second: rd=%b err_rd=%b disp=%b cnt=%0d want 10 10 00 1", rd_out, err_rd, err_disp, err_cnt);
    end
    cycle(1'b1, 2'b00, 2'b00, 20'h0, 1'b0);
    n_tests++;
    if (err_rd !== 2'b00 || err_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL rdv_pulse: err_rd=%b cnt=%0d want 00 1", err_rd, err_cnt);
    end
  endtask

  task automatic test_disp_error();
    cycle(1'b1, 2'b00, 2'b01, {10'b0, 10'b1111111100}, 1'b0);
    n_tests++;
    if (err_disp !== 2'b01 || err_rd !== 2'b00 || rd_out !== 2'b11 || err_cnt !== 4'd2) begin
      n_fail++;
      $display("FAIL disp_err: disp=%b rdv=%b rd=%b cnt=%0d want 01 00 11 2", err_disp, err_rd, rd_out, err_cnt);
    end
  endtask

  task automatic test_simultaneous();
    cycle(1'b1, 2'b00, 2'b00, 20'h0, 1'b1);
    n_tests++;
    if (err_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL clr_idle: cnt=%0d want 0", err_cnt);
    end
    for (int k = 1; k <= 9; k++) begin
      cycle(1'b1, 2'b00, 2'b11, 20'hFFFFF, 1'b0);
      if (k == 1 || k >= 8) begin
        n_tests++;
        if (err_disp !== 2'b11 || err_cnt !== CNT_W'((2 * k > CMAX) ? CMAX : 2 * k)) begin
          n_fail++;
          $display("FAIL sim_err_k%0d: disp=%b cnt=%0d want 11 %0d", k, err_disp, err_cnt,
                   (2 * k > CMAX) ? CMAX : 2 * k);
        end
      end
    end
    cycle(1'b1, 2'b01, 2'b01, 20'hFFFFF, 1'b0);
    n_tests++;
    if (rd_out !== 2'b10 || (err_disp | err_rd) !== 2'b00 || err_cnt !== 4'hF) begin
      n_fail++;
      $display("FAIL start_push: rd=%b errs=%b cnt=%0d want 10 00 15", rd_out, err_disp | err_rd, err_cnt);
    end
    cycle(1'b1, 2'b00, 2'b11, 20'hFFFFF, 1'b1);
    n_tests++;
    if (err_cnt !== 4'd0 || err_disp !== 2'b11 || rd_out !== 2'b11) begin
      n_fail++;
      $display("FAIL clr_with_err: cnt=%0d disp=%b rd=%b want 0 11 11", err_cnt, err_disp, rd_out);
    end
  endtask

  task automatic test_midstream_reset();
    cycle(1'b1, 2'b00, 2'b10, {10'b1111111111, 10'b0}, 1'b0);
    cycle(1'b0, 2'b00, 2'b10, {10'b1111110000, 10'b0}, 1'b0);
    n_tests++;
    if (rd_out !== 2'b00 || err_cnt !== 4'd0 || (err_disp | err_rd) !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_reset: rd=%b cnt=%0d errs=%b want 00 0 00", rd_out, err_cnt, err_disp | err_rd);
    end
    cycle(1'b1, 2'b00, 2'b00, 20'h0, 1'b0);
    n_tests++;
    if (rd_out !== 2'b00 || err_cnt !== 4'd0 || (err_disp | err_rd) !== 2'b00) begin
      n_fail++;
      $display("FAIL post_reset: rd=%b cnt=%0d errs=%b want 00 0 00", rd_out, err_cnt, err_disp | err_rd);
    end
  endtask

  task automatic test_random();
    logic       rst_n;
    logic [1:0] st;
    logic [1:0] pu;
    logic       cl;
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      st[0] = ($urandom_range(0, 15) == 0);
      st[1] = ($urandom_range(0, 15) == 0);
      pu[0] = ($urandom_range(0, 3) != 0);
      pu[1] = ($urandom_range(0, 3) != 0);
      cl    = ($urandom_range(0, 39) == 0);
      cycle(rst_n, st, pu, {gen_sym(), gen_sym()}, cl);
      n_tests++;
      if (rd_out !== m_rd || err_disp !== m_disp || err_rd !== m_rdv || err_cnt !== CNT_W'(m_cnt)) begin
        n_fail++;
        $display("FAIL random_%0d: rd=%b disp=%b rdv=%b cnt=%0d want %b %b %b %0d",
                 i, rd_out, err_disp, err_rd, err_cnt, m_rd, m_disp, m_rdv, m_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_neutral();
    test_alternation();
    test_rd_violation();
    test_disp_error();
    test_simultaneous();
    test_midstream_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
